// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - datapath control bus between sequencer and datapath
interface control_sequencer_if #(
    parameter int OPW  = 5,
    parameter int CNTW = 16
);
    logic            run;
    logic            mem_rdy;
    logic [31:0]     ir;
    logic            PCout;
    logic            Zlowout;
    logic            Zhighout;
    logic            MDRout;
    logic            PCin;
    logic            MARin;
    logic            MDRin;
    logic            IRin;
    logic            Yin;
    logic            Zin;
    logic            LOin;
    logic            HIin;
    logic            IncPC;
    logic            Read;
    logic [15:0]     Rout;
    logic [15:0]     Rin;
    logic [OPW-1:0]  alu_control;
    logic            done;
    logic            illegal;
    logic            halted;
    logic [CNTW-1:0] instr_count;

    modport master (
        input  run, mem_rdy, ir,
        output PCout, Zlowout, Zhighout, MDRout,
        output PCin, MARin, MDRin, IRin, Yin, Zin, LOin, HIin,
        output IncPC, Read, Rout, Rin, alu_control,
        output done, illegal, halted, instr_count
    );

    modport slave (
        output run, mem_rdy, ir,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  PCin, MARin, MDRin, IRin, Yin, Zin, LOin, HIin,
        input  IncPC, Read, Rout, Rin, alu_control,
        input  done, illegal, halted, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hard-wired T-state fetch/execute control unit
module control_sequencer #(
    parameter int OPW  = 5,
    parameter int CNTW = 16
) (
    input  logic clk,
    input  logic clr,
    control_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
    } state_t;

    localparam logic [OPW-1:0] OP_ALU3_MAX = OPW'(8);
    localparam logic [OPW-1:0] OP_MUL      = OPW'(15);
    localparam logic [OPW-1:0] OP_DIV      = OPW'(16);
    localparam logic [OPW-1:0] OP_NEG      = OPW'(17);
    localparam logic [OPW-1:0] OP_NOT      = OPW'(18);
    localparam logic [OPW-1:0] OP_HALT     = OPW'(27);

    state_t          state_q;
    state_t          state_d;
    logic [CNTW-1:0] cnt_q;
    logic            done_c;

    logic [OPW-1:0]  op;
    logic [3:0]      ra;
    logic [3:0]      rb;
    logic [3:0]      rc;
    logic            is_alu3;
    logic            is_muldiv;
    logic            is_unary;
    logic            is_halt;
    logic            unused_ir;

    assign op        = bus.ir[31 -: OPW];
    assign ra        = bus.ir[26:23];
    assign rb        = bus.ir[22:19];
    assign rc        = bus.ir[18:15];
    assign unused_ir = ^bus.ir[14:0];

    assign is_alu3   = (op <= OP_ALU3_MAX);
    assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
    assign is_unary  = (op == OP_NEG) || (op == OP_NOT);
    assign is_halt   = (op == OP_HALT);

    assign bus.instr_count = cnt_q;

    // State register and retired-instruction counter; clr aborts any instruction in flight
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (done_c) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    // Moore decode of state and ir into strobes, plus next-state selection
    always_comb begin
        state_d         = state_q;
        done_c          = 1'b0;
        bus.PCout       = 1'b0;
        bus.Zlowout     = 1'b0;
        bus.Zhighout    = 1'b0;
        bus.MDRout      = 1'b0;
        bus.PCin        = 1'b0;
        bus.MARin       = 1'b0;
        bus.MDRin       = 1'b0;
        bus.IRin        = 1'b0;
        bus.Yin         = 1'b0;
        bus.Zin         = 1'b0;
        bus.LOin        = 1'b0;
        bus.HIin        = 1'b0;
        bus.IncPC       = 1'b0;
        bus.Read        = 1'b0;
        bus.Rout        = 16'h0000;
        bus.Rin         = 16'h0000;
        bus.alu_control = '0;
        bus.illegal     = 1'b0;
        bus.halted      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.run) state_d = T0;
            end
            T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                state_d   = T1;
            end
            T1: begin
                // Held while waiting on memory; reloading PC from an unchanged Z is harmless
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_rdy) state_d = T2;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = T3;
            end
            T3: begin
                state_d = T4;
                if (is_alu3) begin
                    bus.Rout = 16'd1 << rb;
                    bus.Yin  = 1'b1;
                end else if (is_muldiv) begin
                    bus.Rout = 16'd1 << ra;
                    bus.Yin  = 1'b1;
                end else if (is_unary) begin
                    bus.Rout        = 16'd1 << rb;
                    bus.Zin         = 1'b1;
                    bus.alu_control = op;
                end else if (is_halt) begin
                    done_c  = 1'b1;
                    state_d = HALT;
                end else begin
                    bus.illegal = 1'b1;
                    state_d     = T0;
                end
            end
            T4: begin
                state_d = T0;
                if (is_alu3) begin
                    bus.Rout        = 16'd1 << rc;
                    bus.Zin         = 1'b1;
                    bus.alu_control = op;
                    state_d         = T5;
                end else if (is_muldiv) begin
                    bus.Rout        = 16'd1 << rb;
                    bus.Zin         = 1'b1;
                    bus.alu_control = op;
                    state_d         = T5;
                end else if (is_unary) begin
                    bus.Zlowout = 1'b1;
                    bus.Rin     = 16'd1 << ra;
                    done_c      = 1'b1;
                end
            end
            T5: begin
                state_d = T0;
                if (is_alu3) begin
                    bus.Zlowout = 1'b1;
                    bus.Rin     = 16'd1 << ra;
                    done_c      = 1'b1;
                end else if (is_muldiv) begin
                    bus.Zlowout = 1'b1;
                    bus.LOin    = 1'b1;
                    state_d     = T6;
                end
            end
            T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                done_c       = 1'b1;
                state_d      = T0;
            end
            HALT: begin
                bus.halted = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        bus.done = done_c;
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;
    localparam logic [13:0] PCOUT  = 14'h2000;
    localparam logic [13:0] ZLOW   = 14'h1000;
    localparam logic [13:0] ZHIGH  = 14'h0800;
    localparam logic [13:0] MDROUT = 14'h0400;
    localparam logic [13:0] PCIN   = 14'h0200;
    localparam logic [13:0] MARIN  = 14'h0100;
    localparam logic [13:0] MDRIN  = 14'h0080;
    localparam logic [13:0] IRIN   = 14'h0040;
    localparam logic [13:0] YIN    = 14'h0020;
    localparam logic [13:0] ZIN    = 14'h0010;
    localparam logic [13:0] LOIN   = 14'h0008;
    localparam logic [13:0] HIIN   = 14'h0004;
    localparam logic [13:0] INCPC  = 14'h0002;
    localparam logic [13:0] READ   = 14'h0001;
    localparam logic [2:0]  F_DONE = 3'b100;
    localparam logic [2:0]  F_ILL  = 3'b010;
    localparam logic [2:0]  F_HALT = 3'b001;

    typedef struct {
        string       name;
        logic [69:0] v;
        logic [2:0]  c3;
    } exp_t;

    logic clk;
    logic clr;
    exp_t q[$];
    int   vectors;
    int   miscompares;
    logic [15:0] exp_cnt;
    logic [2:0]  exp_c3;

    control_sequencer_if #(.OPW(5), .CNTW(16)) bus ();
    control_sequencer_if #(.OPW(5), .CNTW(3))  bus_s ();

    assign bus_s.run     = bus.run;
    assign bus_s.mem_rdy = bus.mem_rdy;
    assign bus_s.ir      = bus.ir;

    control_sequencer #(.OPW(5), .CNTW(16)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    control_sequencer #(.OPW(5), .CNTW(3)) dut_s (
        .clk (clk),
        .clr (clr),
        .bus (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation per cycle and compares away from the active edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [69:0] act;
            e   = q.pop_front();
            act = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.PCin, bus.MARin,
                   bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.LOin, bus.HIin, bus.IncPC,
                   bus.Read, bus.Rout, bus.Rin, bus.alu_control, bus.done, bus.illegal,
                   bus.halted, bus.instr_count};
            vectors++;
            if (act !== e.v) begin
                miscompares++;
                $display("FAIL %s: got=%h exp=%h", e.name, act, e.v);
            end
            vectors++;
            if (bus_s.instr_count !== e.c3) begin
                miscompares++;
                $display("FAIL %s_cnt3: got=%0d exp=%0d", e.name, bus_s.instr_count, e.c3);
            end
        end
    end

    task automatic step(input string name, input logic [13:0] s, input logic [15:0] ro,
                        input logic [15:0] ri, input logic [4:0] alu, input logic [2:0] f);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = name;
        e.v    = {s, ro, ri, alu, f, exp_cnt};
        e.c3   = exp_c3;
        q.push_back(e);
        if (f[2]) begin
            exp_cnt = exp_cnt + 16'd1;
            exp_c3  = exp_c3 + 3'd1;
        end
    endtask

    task automatic fetch(input string name, input logic [31:0] nir);
        step({name, "_t0"}, PCOUT | MARIN | INCPC | ZIN, 16'h0, 16'h0, 5'd0, 3'b0);
        bus.ir = nir;
        step({name, "_t1"}, ZLOW | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'd0, 3'b0);
        step({name, "_t2"}, MDROUT | IRIN, 16'h0, 16'h0, 5'd0, 3'b0);
    endtask

    task automatic clr_cycle(input string name);
        clr     = 1'b1;
        exp_cnt = 16'd0;
        exp_c3  = 3'd0;
        step(name, 14'h0, 16'h0, 16'h0, 5'd0, 3'b0);
        clr     = 1'b0;
    endtask

    initial begin
        logic [3:0] a;
        logic [3:0] b;
        vectors     = 0;
        miscompares = 0;
        exp_cnt     = 16'd0;
        exp_c3      = 3'd0;
        bus.run     = 1'b0;
        bus.mem_rdy = 1'b0;
        bus.ir      = 32'h0;
        clr         = 1'b1;
        repeat (3) step("reset", 14'h0, 16'h0, 16'h0, 5'd0, 3'b0);
        clr = 1'b0;
        step("idle_run0", 14'h0, 16'h0, 16'h0, 5'd0, 3'b0);

        // shra R1,R2,R3 with no stall
        bus.run     = 1'b1;
        bus.mem_rdy = 1'b1;
        fetch("alu", 32'h28918000);
        step("alu_t3", YIN, 16'h0004, 16'h0, 5'd0, 3'b0);
        step("alu_t4", ZIN, 16'h0008, 16'h0, 5'b00101, 3'b0);
        step("alu_t5", ZLOW, 16'h0, 16'h0002, 5'd0, F_DONE);

        // Same instruction, memory stalls 4 cycles, run dropped mid-instruction
        step("stall_t0", PCOUT | MARIN | INCPC | ZIN, 16'h0, 16'h0, 5'd0, 3'b0);
        bus.mem_rdy = 1'b0;
        bus.run     = 1'b0;
        repeat (5) step("stall_t1", ZLOW | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'd0, 3'b0);
        bus.mem_rdy = 1'b1;
        step("stall_t2", MDROUT | IRIN, 16'h0, 16'h0, 5'd0, 3'b0);
        step("stall_t3", YIN, 16'h0004, 16'h0, 5'd0, 3'b0);
        step("stall_t4", ZIN, 16'h0008, 16'h0, 5'b00101, 3'b0);
        step("stall_t5", ZLOW, 16'h0, 16'h0002, 5'd0, F_DONE);

        // mul R2,R2 - free-running into T0 even though run is low
        fetch("mul", 32'h79100000);
        bus.run = 1'b1;
        step("mul_t3", YIN, 16'h0004, 16'h0, 5'd0, 3'b0);
        step("mul_t4", ZIN, 16'h0004, 16'h0, 5'b01111, 3'b0);
        step("mul_t5", ZLOW | LOIN, 16'h0, 16'h0, 5'd0, 3'b0);
        step("mul_t6", ZHIGH | HIIN, 16'h0, 16'h0, 5'd0, F_DONE);

        // not R5,R6
        fetch("not", {5'b10010, 4'd5, 4'd6, 19'd0});
        step("not_t3", ZIN, 16'h0040, 16'h0, 5'b10010, 3'b0);
        step("not_t4", ZLOW, 16'h0, 16'h0020, 5'd0, F_DONE);

        // neg sweep over register indices; carries the narrow counter through its wrap
        for (int i = 0; i < 9; i++) begin
            a = 4'(i * 2 + 1);
            b = 4'(15 - i);
            fetch("neg", {5'b10001, a, b, 19'd0});
            step("neg_t3", ZIN, 16'd1 << b, 16'h0, 5'b10001, 3'b0);
            step("neg_t4", ZLOW, 16'h0, 16'd1 << a, 5'd0, F_DONE);
        end

        // Undefined opcode: illegal pulse, not counted
        fetch("ill", {5'b11111, 27'd0});
        step("ill_t3", 14'h0, 16'h0, 16'h0, 5'd0, F_ILL);
        step("ill_next_t0", PCOUT | MARIN | INCPC | ZIN, 16'h0, 16'h0, 5'd0, 3'b0);
        step("ill_next_t1", ZLOW | PCIN | READ | MDRIN, 16'h0, 16'h0, 5'd0, 3'b0);
        step("ill_next_t2", MDROUT | IRIN, 16'h0, 16'h0, 5'd0, 3'b0);

        // clr in T4 of an ALU instruction
        bus.ir = 32'h28918000;
        step("abort_t3", YIN, 16'h0004, 16'h0, 5'd0, 3'b0);
        step("abort_t4", ZIN, 16'h0008, 16'h0, 5'b00101, 3'b0);
        bus.run = 1'b0;
        clr_cycle("abort_clr");
        step("abort_idle", 14'h0, 16'h0, 16'h0, 5'd0, 3'b0);
        bus.run = 1'b1;

        // halt, then run toggling is ignored until clr
        fetch("halt", {5'b11011, 27'd0});
        step("halt_t3", 14'h0, 16'h0, 16'h0, 5'd0, F_DONE);
        step("halted", 14'h0, 16'h0, 16'h0, 5'd0, F_HALT);
        bus.run = 1'b0;
        step("halted_run0", 14'h0, 16'h0, 16'h0, 5'd0, F_HALT);
        bus.run = 1'b1;
        step("halted_run1", 14'h0, 16'h0, 16'h0, 5'd0, F_HALT);
        bus.run = 1'b0;
        clr_cycle("halt_clr");
        step("post_halt_idle", 14'h0, 16'h0, 16'h0, 5'd0, 3'b0);

        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got=%0d pending exp=0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
